// File: rtl/micro_step_pkg.sv
// Shared definitions for the micro-step decoder: step codes, control-word
// field layout, register/bus/ALU encodings and the decode table constant.
package micro_step_pkg;

    localparam int CODE_W    = 6;
    localparam int NUM_CODES = 64;
    localparam int WORD_W    = 20;

    typedef logic [CODE_W-1:0] step_code_t;
    typedef logic [WORD_W-1:0] ctrl_word_t;
    typedef logic [NUM_CODES-1:0][WORD_W-1:0] decode_table_t;

    typedef enum logic [1:0] {
        EXEC,
        MEM_WAIT,
        HALT
    } dec_state_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_NOT  = 3'd6,
        ALU_SHL  = 3'd7
    } alu_op_t;

    // Control-word field layout
    localparam int BUS_SEL_LSB = 0;
    localparam int BUS_SEL_W   = 4;
    localparam int LD_EN_LSB   = 4;
    localparam int LD_EN_W     = 8;
    localparam int INC_PC_BIT  = 12;
    localparam int INC_AR_BIT  = 13;
    localparam int ALU_OP_LSB  = 14;
    localparam int ALU_OP_W    = 3;
    localparam int MEM_RD_BIT  = 17;
    localparam int MEM_WR_BIT  = 18;
    localparam int Z_LOAD_BIT  = 19;

    // Step codes
    localparam step_code_t STEP_FETCH1    = 6'd1;
    localparam step_code_t STEP_FETCH2    = 6'd2;
    localparam step_code_t STEP_FETCH3    = 6'd3;
    localparam step_code_t STEP_STORE     = 6'd4;
    localparam step_code_t STEP_LOAD_PC   = 6'd5;
    localparam step_code_t STEP_ALU_FIRST = 6'd36;
    localparam step_code_t STEP_ALU_LAST  = 6'd51;
    localparam step_code_t STEP_NOP       = 6'd56;
    localparam step_code_t STEP_HALT      = 6'd57;

    // Bus sources
    localparam logic [3:0] BUS_PC  = 4'd1;
    localparam logic [3:0] BUS_ACC = 4'd2;
    localparam logic [3:0] BUS_DR  = 4'd4;
    localparam logic [3:0] BUS_TR  = 4'd5;

    // Register indices and their load-enable masks
    localparam int REG_AR  = 0;
    localparam int REG_ACC = 1;
    localparam int REG_IR  = 2;
    localparam int REG_DR  = 3;
    localparam int REG_TR  = 4;
    localparam int REG_PC  = 5;

    localparam logic [7:0] LD_AR  = 8'(1) << REG_AR;
    localparam logic [7:0] LD_ACC = 8'(1) << REG_ACC;
    localparam logic [7:0] LD_IR  = 8'(1) << REG_IR;
    localparam logic [7:0] LD_DR  = 8'(1) << REG_DR;
    localparam logic [7:0] LD_TR  = 8'(1) << REG_TR;
    localparam logic [7:0] LD_PC  = 8'(1) << REG_PC;

    function automatic ctrl_word_t make_word(
        input logic [3:0] bus_sel,
        input logic [7:0] ld_en,
        input logic       inc_pc,
        input logic       inc_ar,
        input alu_op_t    alu_op,
        input logic       mem_rd,
        input logic       mem_wr,
        input logic       z_load
    );
        ctrl_word_t w;
        w = '0;
        w[BUS_SEL_LSB +: BUS_SEL_W] = bus_sel;
        w[LD_EN_LSB +: LD_EN_W]     = ld_en;
        w[INC_PC_BIT]               = inc_pc;
        w[INC_AR_BIT]               = inc_ar;
        w[ALU_OP_LSB +: ALU_OP_W]   = alu_op;
        w[MEM_RD_BIT]               = mem_rd;
        w[MEM_WR_BIT]               = mem_wr;
        w[Z_LOAD_BIT]               = z_load;
        return w;
    endfunction

    // ALU/move block: lower eight target ACC from DR, upper eight target TR
    // from TR; Z is captured whenever a real ALU operation is performed.
    function automatic decode_table_t build_table();
        decode_table_t t;
        int            k;
        alu_op_t       op;
        t = '0;
        t[STEP_FETCH1]  = make_word(BUS_PC, LD_AR, 1'b0, 1'b0, ALU_PASS, 1'b0, 1'b0, 1'b0);
        t[STEP_FETCH2]  = make_word(4'd0, LD_DR, 1'b1, 1'b0, ALU_PASS, 1'b1, 1'b0, 1'b0);
        t[STEP_FETCH3]  = make_word(BUS_DR, LD_IR, 1'b0, 1'b0, ALU_PASS, 1'b0, 1'b0, 1'b0);
        t[STEP_STORE]   = make_word(BUS_ACC, 8'h00, 1'b0, 1'b1, ALU_PASS, 1'b0, 1'b1, 1'b0);
        t[STEP_LOAD_PC] = make_word(BUS_DR, LD_PC, 1'b0, 1'b0, ALU_PASS, 1'b0, 1'b0, 1'b0);
        for (int c = int'(STEP_ALU_FIRST); c <= int'(STEP_ALU_LAST); c++) begin
            k  = c - int'(STEP_ALU_FIRST);
            op = alu_op_t'(k[2:0]);
            t[6'(c)] = make_word(k[3] ? BUS_TR : BUS_DR, k[3] ? LD_TR : LD_ACC,
                                 1'b0, 1'b0, op, 1'b0, 1'b0, (k[2:0] != 3'd0));
        end
        return t;
    endfunction

    // Codes that have a defined meaning; everything else is illegal
    function automatic logic [NUM_CODES-1:0] build_legal();
        logic [NUM_CODES-1:0] m;
        m = '0;
        m[STEP_FETCH1]  = 1'b1;
        m[STEP_FETCH2]  = 1'b1;
        m[STEP_FETCH3]  = 1'b1;
        m[STEP_STORE]   = 1'b1;
        m[STEP_LOAD_PC] = 1'b1;
        for (int c = int'(STEP_ALU_FIRST); c <= int'(STEP_ALU_LAST); c++) begin
            m[6'(c)] = 1'b1;
        end
        m[STEP_NOP]  = 1'b1;
        m[STEP_HALT] = 1'b1;
        return m;
    endfunction

    localparam decode_table_t        DECODE_TABLE = build_table();
    localparam logic [NUM_CODES-1:0] LEGAL_MASK   = build_legal();

endpackage

// File: rtl/micro_step_decoder_if.sv
// Micro-step interface between the sequencer (master) and the decoder (slave).
// Optional macro STEP_PERF_CNT_EN adds the step_count/stall_count counters.
interface micro_step_decoder_if #(
    parameter int NUM_REGS = 8
);
    import micro_step_pkg::*;

    step_code_t          step_code;
    logic                mem_ack;
    logic                step_ready;
    logic [3:0]          bus_sel;
    logic [NUM_REGS-1:0] ld_en;
    logic                inc_pc;
    logic                inc_ar;
    logic [2:0]          alu_op;
    logic                mem_rd;
    logic                mem_wr;
    logic                z_load;
    logic                halted;
    logic                illegal_step;
    logic                mem_err;
`ifdef STEP_PERF_CNT_EN
    logic [15:0]         step_count;
    logic [15:0]         stall_count;

    modport master (
        output step_code, mem_ack,
        input  step_ready, bus_sel, ld_en, inc_pc, inc_ar, alu_op,
               mem_rd, mem_wr, z_load, halted, illegal_step, mem_err,
               step_count, stall_count
    );

    modport slave (
        input  step_code, mem_ack,
        output step_ready, bus_sel, ld_en, inc_pc, inc_ar, alu_op,
               mem_rd, mem_wr, z_load, halted, illegal_step, mem_err,
               step_count, stall_count
    );
`else
    modport master (
        output step_code, mem_ack,
        input  step_ready, bus_sel, ld_en, inc_pc, inc_ar, alu_op,
               mem_rd, mem_wr, z_load, halted, illegal_step, mem_err
    );

    modport slave (
        input  step_code, mem_ack,
        output step_ready, bus_sel, ld_en, inc_pc, inc_ar, alu_op,
               mem_rd, mem_wr, z_load, halted, illegal_step, mem_err
    );
`endif

endinterface

// File: rtl/step_rom.sv
// Combinational decode-table lookup with an illegal-code flag.
module step_rom
    import micro_step_pkg::*;
(
    input  step_code_t step_code,
    output ctrl_word_t word,
    output logic       illegal
);

    // Table lookup; undefined codes read back as an all-zero word
    always_comb begin
        word    = DECODE_TABLE[step_code];
        illegal = ~LEGAL_MASK[step_code];
    end

endmodule

// File: rtl/micro_step_decoder.sv
// Micro-step decoder: expands sequencer codes into a registered datapath
// control word, stalls the sequencer during memory accesses and latches HALT.
// Optional macro STEP_PERF_CNT_EN adds saturating step/stall counters.
module micro_step_decoder
    import micro_step_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int NUM_REGS    = 8
) (
    input logic                 clk,
    input logic                 rst,
    micro_step_decoder_if.slave step_if
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    dec_state_t       state;
    ctrl_word_t       word_q;
    ctrl_word_t       rom_word;
    logic             rom_illegal;
    logic             ready_q;
    logic             halted_q;
    logic             illegal_q;
    logic             mem_err_q;
    logic [CNT_W-1:0] wait_cnt;

    step_rom u_rom (
        .step_code (step_if.step_code),
        .word      (rom_word),
        .illegal   (rom_illegal)
    );

    // Control FSM: accept codes in EXEC, hold the word through a memory
    // access until ack or timeout, and park in HALT until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EXEC;
            word_q    <= '0;
            ready_q   <= 1'b1;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            unique case (state)
                EXEC: begin
                    wait_cnt <= '0;
                    if (step_if.step_code == STEP_HALT) begin
                        word_q   <= '0;
                        halted_q <= 1'b1;
                        ready_q  <= 1'b0;
                        state    <= HALT;
                    end else if (rom_illegal) begin
                        word_q    <= '0;
                        illegal_q <= 1'b1;
                    end else begin
                        word_q <= rom_word;
                        if (rom_word[MEM_RD_BIT] || rom_word[MEM_WR_BIT]) begin
                            ready_q <= 1'b0;
                            state   <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (step_if.mem_ack) begin
                        word_q   <= '0;
                        ready_q  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= EXEC;
                    end else if (wait_cnt == CNT_LAST) begin
                        word_q    <= '0;
                        ready_q   <= 1'b1;
                        mem_err_q <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= EXEC;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HALT: begin
                    word_q   <= '0;
                    ready_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    word_q  <= '0;
                    ready_q <= 1'b1;
                    state   <= EXEC;
                end
            endcase
        end
    end

    assign step_if.step_ready   = ready_q;
    assign step_if.bus_sel      = word_q[BUS_SEL_LSB +: BUS_SEL_W];
    assign step_if.ld_en        = NUM_REGS'(word_q[LD_EN_LSB +: LD_EN_W]);
    assign step_if.inc_pc       = word_q[INC_PC_BIT];
    assign step_if.inc_ar       = word_q[INC_AR_BIT];
    assign step_if.alu_op       = word_q[ALU_OP_LSB +: ALU_OP_W];
    assign step_if.mem_rd       = word_q[MEM_RD_BIT];
    assign step_if.mem_wr       = word_q[MEM_WR_BIT];
    assign step_if.z_load       = word_q[Z_LOAD_BIT];
    assign step_if.halted       = halted_q;
    assign step_if.illegal_step = illegal_q;
    assign step_if.mem_err      = mem_err_q;

`ifdef STEP_PERF_CNT_EN
    logic [15:0] step_cnt_q;
    logic [15:0] stall_cnt_q;

    // Saturating counts of accepted codes and of memory stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state == EXEC && step_cnt_q != 16'hFFFF) begin
                step_cnt_q <= step_cnt_q + 16'd1;
            end
            if (state == MEM_WAIT && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign step_if.step_count  = step_cnt_q;
    assign step_if.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_micro_step_decoder.sv
// Self-checking bench for micro_step_decoder: directed scenarios followed by
// randomized codes/acks/resets, all checked against a cycle-level reference.
module tb_micro_step_decoder;

    localparam int MEM_TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    micro_step_decoder_if #(.NUM_REGS(8)) dut_if ();

    micro_step_decoder #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .NUM_REGS    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .step_if (dut_if)
    );

    typedef struct packed {
        logic [3:0] bus_sel;
        logic [7:0] ld_en;
        logic       inc_pc;
        logic       inc_ar;
        logic [2:0] alu_op;
        logic       mem_rd;
        logic       mem_wr;
        logic       z_load;
    } word_t;

    int compared   = 0;
    int mismatched = 0;

    // Reference state, expressed as what the sequencer observes
    word_t m_word;
    bit    m_valid  = 1'b0;
    bit    m_ready, m_halted, m_illegal, m_err, m_busy;
    int    m_wait, m_steps, m_stalls;
    int    last_code = 56;

    // Expected control word from the instruction-set description
    function automatic bit refDecode(input int code, output word_t w);
        int k;
        w = '0;
        if (code == 1) begin w.bus_sel = 4'd1; w.ld_en = 8'h01; return 1'b1; end
        if (code == 2) begin w.mem_rd = 1'b1; w.ld_en = 8'h08; w.inc_pc = 1'b1; return 1'b1; end
        if (code == 3) begin w.bus_sel = 4'd4; w.ld_en = 8'h04; return 1'b1; end
        if (code == 4) begin w.bus_sel = 4'd2; w.inc_ar = 1'b1; w.mem_wr = 1'b1; return 1'b1; end
        if (code == 5) begin w.bus_sel = 4'd4; w.ld_en = 8'h20; return 1'b1; end
        if (code >= 36 && code <= 51) begin
            k = code - 36;
            w.alu_op  = 3'(k % 8);
            w.bus_sel = (k < 8) ? 4'd4 : 4'd5;
            w.ld_en   = (k < 8) ? 8'h02 : 8'h10;
            w.z_load  = ((k % 8) != 0);
            return 1'b1;
        end
        if (code == 56 || code == 57) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the reference by one clock edge with the given inputs
    task automatic modelStep(input bit r, input int code, input bit ack);
        word_t w;
        bit    legal;
        m_illegal = 1'b0;
        m_err     = 1'b0;
        if (r) begin
            m_valid = 1'b1; m_word = '0; m_ready = 1'b1; m_halted = 1'b0;
            m_busy = 1'b0; m_wait = 0; m_steps = 0; m_stalls = 0;
        end else if (!m_valid) begin
            m_word = '0;
        end else if (m_halted) begin
            m_word  = '0;
            m_ready = 1'b0;
        end else if (m_busy) begin
            if (m_stalls < 65535) m_stalls++;
            m_wait++;
            if (ack) begin
                m_busy = 1'b0; m_word = '0; m_ready = 1'b1;
            end else if (m_wait == MEM_TIMEOUT) begin
                m_err = 1'b1; m_busy = 1'b0; m_word = '0; m_ready = 1'b1;
            end
        end else begin
            if (m_steps < 65535) m_steps++;
            legal = refDecode(code, w);
            if (code == 57) begin
                m_halted = 1'b1; m_word = '0; m_ready = 1'b0;
            end else if (!legal) begin
                m_word = '0; m_illegal = 1'b1;
            end else begin
                m_word = w;
                if (w.mem_rd || w.mem_wr) begin
                    m_busy = 1'b1; m_wait = 0; m_ready = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic compareAll();
        if (!m_valid) return;
        checkOutput("step_ready",   32'(dut_if.step_ready),   32'(m_ready));
        checkOutput("bus_sel",      32'(dut_if.bus_sel),      32'(m_word.bus_sel));
        checkOutput("ld_en",        32'(dut_if.ld_en),        32'(m_word.ld_en));
        checkOutput("inc_pc",       32'(dut_if.inc_pc),       32'(m_word.inc_pc));
        checkOutput("inc_ar",       32'(dut_if.inc_ar),       32'(m_word.inc_ar));
        checkOutput("alu_op",       32'(dut_if.alu_op),       32'(m_word.alu_op));
        checkOutput("mem_rd",       32'(dut_if.mem_rd),       32'(m_word.mem_rd));
        checkOutput("mem_wr",       32'(dut_if.mem_wr),       32'(m_word.mem_wr));
        checkOutput("z_load",       32'(dut_if.z_load),       32'(m_word.z_load));
        checkOutput("halted",       32'(dut_if.halted),       32'(m_halted));
        checkOutput("illegal_step", 32'(dut_if.illegal_step), 32'(m_illegal));
        checkOutput("mem_err",      32'(dut_if.mem_err),      32'(m_err));
`ifdef STEP_PERF_CNT_EN
        checkOutput("step_count",   32'(dut_if.step_count),   32'(m_steps));
        checkOutput("stall_count",  32'(dut_if.stall_count),  32'(m_stalls));
`endif
    endtask

    // Check the outputs of the previous edge, then drive inputs for the next
    task automatic applyStimulus(input bit r, input int code, input bit ack);
        @(negedge clk);
        compareAll();
        rst               = r;
        dut_if.step_code  = 6'(code);
        dut_if.mem_ack    = ack;
        last_code         = code;
        modelStep(r, code, ack);
    endtask

    initial begin
        int code;
        int sel;
        bit r;
        bit ack;

        dut_if.step_code = 6'd0;
        dut_if.mem_ack   = 1'b0;

        // Reset, then a single-cycle fetch step
        applyStimulus(1'b1, 56, 1'b0);
        applyStimulus(1'b0, 1, 1'b0);
        applyStimulus(1'b0, 56, 1'b0);
        applyStimulus(1'b0, 56, 1'b0);

        // Memory read acknowledged in the fourth wait cycle
        applyStimulus(1'b0, 2, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2, 1'b0);
        applyStimulus(1'b0, 2, 1'b1);
        applyStimulus(1'b0, 3, 1'b0);
        applyStimulus(1'b0, 56, 1'b0);

        // Memory read that times out
        applyStimulus(1'b0, 2, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) applyStimulus(1'b0, 2, 1'b0);
        applyStimulus(1'b0, 56, 1'b0);

        // Ack coinciding with the timeout edge wins
        applyStimulus(1'b0, 4, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) applyStimulus(1'b0, 4, 1'b0);
        applyStimulus(1'b0, 4, 1'b1);
        applyStimulus(1'b0, 56, 1'b0);

        // Illegal codes and an ack outside a memory access
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 63, 1'b0);
        applyStimulus(1'b0, 1, 1'b1);
        applyStimulus(1'b0, 37, 1'b0);
        applyStimulus(1'b0, 44, 1'b0);

        // Halt is sticky until reset
        applyStimulus(1'b0, 57, 1'b0);
        for (int c = 1; c <= 3; c++) applyStimulus(1'b0, c, 1'b0);
        applyStimulus(1'b1, 56, 1'b0);
        applyStimulus(1'b0, 56, 1'b0);

        // Reset in the middle of a memory access
        applyStimulus(1'b0, 2, 1'b0);
        applyStimulus(1'b0, 2, 1'b0);
        applyStimulus(1'b0, 2, 1'b0);
        applyStimulus(1'b1, 2, 1'b0);
        applyStimulus(1'b0, 56, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            ack = ($urandom_range(0, 5) == 0);
            if (!m_ready && !m_halted) begin
                code = last_code;
            end else if ($urandom_range(0, 9) < 7) begin
                sel  = int'($urandom_range(0, 21));
                code = (sel < 5) ? sel + 1 : (sel < 21) ? 36 + sel - 5 : 56;
            end else begin
                code = int'($urandom_range(0, 63));
            end
            applyStimulus(r, code, ack);
        end

        @(negedge clk);
        compareAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/micro_step_decoder.md
Name: micro_step_decoder

Overview:
- Consumer end of the sequencer's micro-step interface.
- Samples the 6-bit micro-step code issued each cycle and expands it into a registered datapath control word: bus source select, register load enables, increments, ALU op, memory strobes and Z-flag load.
- Stalls the sequencer during memory accesses through a ready/ack handshake.
- Latches HALT until reset.

Parameters:
- MEM_TIMEOUT, 15, max cycles spent in MEM_WAIT before mem_err is raised and the access is abandoned.
- NUM_REGS, 8, width of ld_en (one bit per loadable register).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset: one clock, synchronous, active-high
- step_code  in  6  micro-step code from the sequencer, held stable while step_ready=0
- mem_ack  in  1  memory completes current rd/wr this cycle
- step_ready  out  1  1 = code accepted this cycle; 0 = sequencer must hold code
- bus_sel  out  4  bus source select
- ld_en  out  NUM_REGS  one-hot register load enables
- inc_pc  out  1  PC increment
- inc_ar  out  1  AR increment
- alu_op  out  3  ALU operation
- mem_rd  out  1  memory read strobe, held through MEM_WAIT
- mem_wr  out  1  memory write strobe, held through MEM_WAIT
- z_load  out  1  Z flag capture enable
- halted  out  1  sticky halt
- illegal_step  out  1  one-cycle pulse on an undefined code
- mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset values:
  - state=EXEC; all control outputs 0.
  - step_ready=1, halted=0, illegal_step=0, mem_err=0.
  - timeout counter=0.
  - rst mid-access drops mem_rd/mem_wr on the same edge.
- Latency: a code accepted at edge N drives its control word from edge N+1 for exactly one cycle, unless it enters MEM_WAIT.
- States: EXEC, MEM_WAIT, HALT.
- EXEC:
  - step_ready=1; sample step_code; look up the control word.
  - Word with mem_rd or mem_wr set: register the word, go to MEM_WAIT, step_ready=0 from the next cycle.
  - Code 57: all outputs 0, halted=1, go to HALT.
  - Code 56: NOP, all-zero word.
  - Codes 0 or undefined: all-zero word plus illegal_step pulse, stay in EXEC.
- MEM_WAIT:
  - Hold the entire control word; step_ready=0; counter increments each cycle.
  - mem_ack=1: next edge clears the word, step_ready=1, return to EXEC. The code present in that same cycle is NOT sampled; it is sampled on the following cycle.
  - Counter reaches MEM_TIMEOUT without ack: mem_err pulse, clear the word, return to EXEC.
  - mem_ack in EXEC is ignored.
- HALT:
  - step_ready=0, all outputs 0, halted=1.
  - Only rst exits.
- Simultaneous events:
  - rst has priority over everything.
  - mem_ack and timeout on the same edge: ack wins, no mem_err.
- Decode table:
  - Constant array indexed by step_code, defined in the package.
  - Field layout: [3:0] bus_sel, [11:4] ld_en, [12] inc_pc, [13] inc_ar, [16:14] alu_op, [17] mem_rd, [18] mem_wr, [19] z_load.
- Required entries:
  - 1: bus_sel=PC(1), ld_en=AR(bit0).
  - 2: mem_rd, ld_en=DR(bit3), inc_pc.
  - 3: bus_sel=DR(4), ld_en=IR(bit2).
  - 36..51: single-cycle ALU/move steps with z_load=1 where alu_op≠0.

Optional Feature:
- Macro STEP_PERF_CNT_EN.
- Defined:
  - Adds output step_count[15:0]: increments on every accepted code in EXEC, including NOP/illegal.
  - Saturates at 16'hFFFF; cleared by rst.
  - Adds output stall_count[15:0]: increments each MEM_WAIT cycle; same saturation and reset rules.
- Undefined: neither port nor counter exists; all other behaviour identical.

Decomposition:
- Package micro_step_pkg:
  - Step code constants (STEP_FETCH1..STEP_NOP=56, STEP_HALT=57).
  - Control-word field offsets and widths, register index constants, ALU op codes.
  - Decode table constant.
- Sub-module step_rom:
  - Purely combinational table lookup with an illegal flag.
  - Keeps the FSM file free of table data.

Test Plan:
- Reset, then step_code=1 for one cycle -> next cycle bus_sel=1, ld_en=8'h01, mem_rd=0, step_ready=1; the cycle after, all outputs 0.
- step_code=2, mem_ack asserted 3 cycles later -> mem_rd=1, ld_en=8'h08, inc_pc=1 held 4 cycles; step_ready=0 throughout; released on the edge after ack.
- step_code=2, mem_ack never asserted, MEM_TIMEOUT=15 -> mem_err pulses once after 15 wait cycles; outputs cleared; step_ready=1.
- step_code=0 then 63 -> illegal_step pulses for each; all control outputs 0; state stays EXEC.
- step_code=57, then codes 1..3 -> halted=1 and step_ready=0 persist, no control outputs; rst -> halted=0, step_ready=1.
- rst asserted during MEM_WAIT with mem_rd=1 -> mem_rd=0 on that edge; with STEP_PERF_CNT_EN, step_count=0 and stall_count=0.
